// File: rtl/fifo_v4.sv
// fifo_v4 - parametrised synchronous FIFO with valid/ready handshakes.
//
// Circular buffer of DEPTH entries (any DEPTH >= 2), explicit pointer wrap,
// optional fall-through when empty, programmable almost-full/almost-empty
// thresholds, synchronous flush and a clearable high-watermark register.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush_i           clear contents on next edge; blocks both handshakes
//   wvalid_i/wready_o/wdata_i   write side
//   rvalid_o/rready_i/rdata_o   read side (rdata_o = head entry)
//   af_thr_i/ae_thr_i thresholds for almost_full_o / almost_empty_o
//   usage_o           registered occupancy 0..DEPTH
//   max_usage_o       highest occupancy since reset or last wm_clr_i
//   wm_clr_i          watermark clear (loads next occupancy)
module fifo_v4 #(
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rvalid_o,
  input  logic          rready_i,
  output logic [DW-1:0] rdata_o,
  input  logic [CW-1:0] af_thr_i,
  input  logic [CW-1:0] ae_thr_i,
  output logic [CW-1:0] usage_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [CW-1:0] max_usage_o,
  input  logic          wm_clr_i
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] usage_q, usage_d;
  logic [CW-1:0] max_q, max_d;

  logic empty, full, ft_act;
  logic push, pop, bypass, wr_en, rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty  = (usage_q == '0);
  assign full   = (usage_q == CW'(DEPTH));
  assign ft_act = FALL_THROUGH && empty;

  always_comb begin
    wready_o = ~full & ~flush_i;
    if (ft_act) begin
      rvalid_o = wvalid_i & ~flush_i;
      rdata_o  = wdata_i;
    end else begin
      rvalid_o = ~empty & ~flush_i;
      rdata_o  = mem_q[rptr_q];
    end
  end

  assign push   = wvalid_i & wready_o;
  assign pop    = rvalid_o & rready_i;
  // Fall-through push+pop passes the word straight across; storage untouched.
  assign bypass = ft_act & push & pop;
  assign wr_en  = push & ~bypass;
  assign rd_en  = pop & ~bypass;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    usage_d = usage_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      usage_d = '0;
    end else begin
      if (wr_en) wptr_d = ptr_inc(wptr_q);
      if (rd_en) rptr_d = ptr_inc(rptr_q);
      case ({wr_en, rd_en})
        2'b10:   usage_d = usage_q + CW'(1);
        2'b01:   usage_d = usage_q - CW'(1);
        default: usage_d = usage_q;
      endcase
    end
    if (wm_clr_i) max_d = usage_d;
    else          max_d = (usage_d > max_q) ? usage_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      max_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usage_q <= usage_d;
      max_q   <= max_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  assign usage_o        = usage_q;
  assign max_usage_o    = max_q;
  assign almost_full_o  = (usage_q >= af_thr_i);
  assign almost_empty_o = (usage_q <= ae_thr_i);

endmodule

// File: tb/tb_fifo_v4.sv
// Testbench for fifo_v4: two instances (DEPTH=5, FALL_THROUGH=0 and 1) share
// stimulus. A queue-based reference model checks every cycle; a constant
// vector table and directed sequences pin down the documented scenarios.
module tb_fifo_v4;

  localparam int DEP = 5;

  logic       clk = 1'b0;
  logic       rst, flush, wv, rr, wmclr;
  logic [7:0] wd;
  logic [2:0] af_thr, ae_thr;

  logic       wr0, rv0, af0, ae0, wr1, rv1, af1, ae1;
  logic [7:0] rd0, rd1;
  logic [2:0] us0, mx0, us1, mx1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_v4 #(.DW(8), .DEPTH(DEP), .FALL_THROUGH(1'b0)) u_dut0 (
    .clk(clk), .reset(rst), .flush_i(flush),
    .wvalid_i(wv), .wready_o(wr0), .wdata_i(wd),
    .rvalid_o(rv0), .rready_i(rr), .rdata_o(rd0),
    .af_thr_i(af_thr), .ae_thr_i(ae_thr), .usage_o(us0),
    .almost_full_o(af0), .almost_empty_o(ae0),
    .max_usage_o(mx0), .wm_clr_i(wmclr));

  fifo_v4 #(.DW(8), .DEPTH(DEP), .FALL_THROUGH(1'b1)) u_dut1 (
    .clk(clk), .reset(rst), .flush_i(flush),
    .wvalid_i(wv), .wready_o(wr1), .wdata_i(wd),
    .rvalid_o(rv1), .rready_i(rr), .rdata_o(rd1),
    .af_thr_i(af_thr), .ae_thr_i(ae_thr), .usage_o(us1),
    .almost_full_o(af1), .almost_empty_o(ae1),
    .max_usage_o(mx1), .wm_clr_i(wmclr));

  // ---------------- reference model ----------------
  typedef struct {
    bit       wr, rv, af, ae, push, pop, bypass;
    logic [7:0] rd;
  } exp_t;

  logic [7:0] q0[$], q1[$];
  int   max0 = 0, max1 = 0;
  exp_t e0, e1;

  function automatic exp_t expect_of(int size, logic [7:0] head, bit ft);
    exp_t e;
    bit   fta;
    fta      = ft && (size == 0);
    e.wr     = (size != DEP) && !flush;
    e.rv     = fta ? (wv && !flush) : ((size != 0) && !flush);
    e.rd     = fta ? wd : head;
    e.af     = size >= int'(af_thr);
    e.ae     = size <= int'(ae_thr);
    e.push   = wv && e.wr;
    e.pop    = e.rv && rr;
    e.bypass = fta && e.push && e.pop;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input exp_t e, input int size, input int mx,
                           input logic w, input logic v, input logic [7:0] d,
                           input logic a, input logic ae, input logic [2:0] us,
                           input logic [2:0] m);
    check({tag, ".usage"}, int'(us), size);
    check({tag, ".max_usage"}, int'(m), mx);
    check({tag, ".wready"}, int'(w), int'(e.wr));
    check({tag, ".rvalid"}, int'(v), int'(e.rv));
    check({tag, ".almost_full"}, int'(a), int'(e.af));
    check({tag, ".almost_empty"}, int'(ae), int'(e.ae));
    if (e.rv) check({tag, ".rdata"}, int'(d), int'(e.rd));
  endtask

  // Apply inputs away from the clock edge and compare against the model.
  task automatic drive(input bit r, input bit f, input bit w, input bit rdy,
                       input logic [7:0] d, input bit clr, input bit chk_en);
    logic [7:0] h0, h1;
    rst = r; flush = f; wv = w; rr = rdy; wd = d; wmclr = clr;
    #2;
    h0 = (q0.size() > 0) ? q0[0] : 8'h00;
    h1 = (q1.size() > 0) ? q1[0] : 8'h00;
    e0 = expect_of(q0.size(), h0, 1'b0);
    e1 = expect_of(q1.size(), h1, 1'b1);
    if (chk_en) begin
      cmp_model("m0", e0, q0.size(), max0, wr0, rv0, rd0, af0, ae0, us0, mx0);
      cmp_model("m1", e1, q1.size(), max1, wr1, rv1, rd1, af1, ae1, us1, mx1);
    end
  endtask

  task automatic tick();
    logic [7:0] tmp;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); max0 = 0; max1 = 0;
    end else begin
      if (flush) begin
        q0.delete(); q1.delete();
      end else begin
        if (!e0.bypass) begin
          if (e0.pop) tmp = q0.pop_front();
          if (e0.push) q0.push_back(wd);
        end
        if (!e1.bypass) begin
          if (e1.pop) tmp = q1.pop_front();
          if (e1.push) q1.push_back(wd);
        end
      end
      max0 = wmclr ? q0.size() : ((q0.size() > max0) ? q0.size() : max0);
      max1 = wmclr ? q1.size() : ((q1.size() > max1) ? q1.size() : max1);
    end
    #1;
  endtask

  task automatic step(input bit w, input bit rdy, input logic [7:0] d);
    drive(1'b0, 1'b0, w, rdy, d, 1'b0, 1'b1);
    tick();
  endtask

  // ---------------- constant vector table (DUT0, af_thr=4, ae_thr=0) ----------------
  typedef struct {
    bit chk, rst, wv, rr;
    logic [7:0] wd;
    int us; bit wr, rv; logic [7:0] rd; bit af, ae; int mx;
  } vec_t;

  function automatic vec_t V(bit c, bit r, bit w, bit rdy, logic [7:0] d, int us, bit wr,
                             bit rv, logic [7:0] rd, bit af, bit ae, int mx);
    vec_t t;
    t.chk = c; t.rst = r; t.wv = w; t.rr = rdy; t.wd = d; t.us = us; t.wr = wr;
    t.rv = rv; t.rd = rd; t.af = af; t.ae = ae; t.mx = mx;
    return t;
  endfunction

  vec_t tbl[22];

  initial begin
    tbl[0]  = V(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = V(1, 0, 1, 0, 8'h11, 0, 1, 0, 8'h00, 0, 1, 0);
    tbl[2]  = V(1, 0, 1, 0, 8'h12, 1, 1, 1, 8'h11, 0, 0, 1);
    tbl[3]  = V(1, 0, 1, 0, 8'h13, 2, 1, 1, 8'h11, 0, 0, 2);
    tbl[4]  = V(1, 0, 1, 0, 8'h14, 3, 1, 1, 8'h11, 0, 0, 3);
    tbl[5]  = V(1, 0, 1, 0, 8'h15, 4, 1, 1, 8'h11, 1, 0, 4);
    tbl[6]  = V(1, 0, 1, 0, 8'h16, 5, 0, 1, 8'h11, 1, 0, 5);
    tbl[7]  = V(1, 0, 1, 0, 8'h17, 5, 0, 1, 8'h11, 1, 0, 5);
    tbl[8]  = V(1, 0, 0, 1, 8'h00, 5, 0, 1, 8'h11, 1, 0, 5);
    tbl[9]  = V(1, 0, 0, 1, 8'h00, 4, 1, 1, 8'h12, 1, 0, 5);
    tbl[10] = V(1, 0, 0, 1, 8'h00, 3, 1, 1, 8'h13, 0, 0, 5);
    tbl[11] = V(1, 0, 0, 1, 8'h00, 2, 1, 1, 8'h14, 0, 0, 5);
    tbl[12] = V(1, 0, 0, 1, 8'h00, 1, 1, 1, 8'h15, 0, 0, 5);
    tbl[13] = V(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 5);
    tbl[14] = V(1, 0, 1, 0, 8'h21, 0, 1, 0, 8'h00, 0, 1, 5);
    tbl[15] = V(1, 0, 1, 0, 8'h22, 1, 1, 1, 8'h21, 0, 0, 5);
    tbl[16] = V(1, 0, 1, 0, 8'h23, 2, 1, 1, 8'h21, 0, 0, 5);
    tbl[17] = V(1, 0, 1, 0, 8'h24, 3, 1, 1, 8'h21, 0, 0, 5);
    tbl[18] = V(1, 1, 1, 0, 8'h25, 4, 1, 1, 8'h21, 1, 0, 5);
    tbl[19] = V(1, 0, 1, 0, 8'h31, 0, 1, 0, 8'h00, 0, 1, 0);
    tbl[20] = V(1, 0, 0, 1, 8'h00, 1, 1, 1, 8'h31, 0, 0, 1);
    tbl[21] = V(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; wv = 1'b0; rr = 1'b0; wd = '0; wmclr = 1'b0;
    af_thr = 3'd4; ae_thr = 3'd0;
    #1;

    // Fill/drain at DEPTH=5 and reset mid-operation.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, 1'b0, tbl[i].wv, tbl[i].rr, tbl[i].wd, 1'b0, tbl[i].chk);
      if (tbl[i].chk) begin
        check("tbl.usage", int'(us0), tbl[i].us);
        check("tbl.wready", int'(wr0), int'(tbl[i].wr));
        check("tbl.rvalid", int'(rv0), int'(tbl[i].rv));
        if (tbl[i].rv) check("tbl.rdata", int'(rd0), int'(tbl[i].rd));
        check("tbl.almost_full", int'(af0), int'(tbl[i].af));
        check("tbl.almost_empty", int'(ae0), int'(tbl[i].ae));
        check("tbl.max_usage", int'(mx0), tbl[i].mx);
      end
      tick();
    end

    // Steady state at usage=3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h43 + k), 1'b0, 1'b1);
      check("wrap.usage", int'(us0), 3);
      check("wrap.rdata", int'(rd0), 8'h40 + k);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap.max_usage", int'(mx0), 3);
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Flush mid-traffic at usage=4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h54, 1'b0, 1'b1);
    check("flush.wready", int'(wr0), 0);
    check("flush.rvalid", int'(rv0), 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("flush.usage", int'(us0), 0);
    check("flush.max_usage", int'(mx0), 4);
    tick();
    step(1'b1, 1'b0, 8'h60);
    step(1'b1, 1'b0, 8'h61);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);

    // Watermark: fill 3, drain, fill 2, clear with push, then pop.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'(8'h78 + i));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("wm.max_before_clr", int'(mx0), 3);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h7a, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("wm.max_after_clr", int'(mx0), 3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("wm.max_after_pop", int'(mx0), 3);
    check("wm.usage_after_pop", int'(us0), 2);
    tick();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00);

    // Fall-through on the FALL_THROUGH=1 instance.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    check("ft.rvalid", int'(rv1), 1);
    check("ft.rdata", int'(rd1), 8'hA5);
    check("ft.usage", int'(us1), 0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    check("ft.rvalid_hold", int'(rv1), 1);
    check("ft.rdata_fwd", int'(rd1), 8'hA5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ft.usage_stored", int'(us1), 1);
    check("ft.rdata_held", int'(rd1), 8'hA5);
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      int rr_pct;
      rr_pct = ((c / 50) % 2 == 0) ? 30 : 80;
      if (c % 32 == 0) begin
        af_thr = 3'($urandom_range(0, 7));
        ae_thr = 3'($urandom_range(0, 7));
      end
      drive(($urandom % 97) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
            int'($urandom % 100) < rr_pct, 8'($urandom), ($urandom % 25) == 0, 1'b1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_v4.md
# fifo_v4

Parametrised synchronous FIFO, successor to `fifo_v3` in the common-cell library. It serves as a generic buffer between AXI/AHB bridge stages and peripheral datapaths. Compared with `fifo_v3` it adds:
- a valid/ready handshake on both sides;
- arbitrary (non-power-of-two) depth;
- a compile-time fall-through mode;
- run-time programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- a clearable high-watermark register for buffer sizing in silicon.

## Interface
Parameters:
- `DW`, 32, data width in bits (≥1).
- `DEPTH`, 8, number of storage entries (≥2; any integer, not restricted to powers of two).
- `FALL_THROUGH`, 0, 1 = an empty FIFO forwards write data combinationally to the read port.
- `AW`, derived, `$clog2(DEPTH)`, pointer width.
- `CW`, derived, `$clog2(DEPTH+1)`, occupancy-count width.

Ports:
- `clk`  in  1  clock; the only clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous clear of contents; has priority over all handshakes.
- `wvalid_i`  in  1  write data valid.
- `wready_o`  out  1  FIFO can accept a write.
- `wdata_i`  in  DW  write data.
- `rvalid_o`  out  1  read data valid.
- `rready_i`  in  1  consumer accepts read data.
- `rdata_o`  out  DW  read data (head entry).
- `af_thr_i`  in  CW  almost-full threshold.
- `ae_thr_i`  in  CW  almost-empty threshold.
- `usage_o`  out  CW  current occupancy, 0..DEPTH.
- `almost_full_o`  out  1  asserted when `usage_o >= af_thr_i`.
- `almost_empty_o`  out  1  asserted when `usage_o <= ae_thr_i`.
- `max_usage_o`  out  CW  highest occupancy since reset or the last clear.
- `wm_clr_i`  in  1  clear for the high watermark.

## Operation
- Storage is a circular buffer of `DEPTH` entries with separate read and write pointers, plus a `CW`-bit occupancy counter.
- Pointer wrap: a pointer at `DEPTH-1` advances to 0. There is no reliance on power-of-two rollover.
- Push occurs when `wvalid_i & wready_o`. Pop occurs when `rvalid_o & rready_i`.
- `wready_o = (usage != DEPTH) & ~flush_i`. Whether a write is accepted never depends on `rready_i`, so a full FIFO does not accept a write even in a cycle where it pops.
- `rvalid_o = (usage != 0) & ~flush_i`, except in the fall-through case below.
- Occupancy update: `usage` becomes `usage + push - pop`. Simultaneous push and pop leaves the count unchanged.
- Fall-through (`FALL_THROUGH=1`) applies when `usage==0`:
  - `rvalid_o = wvalid_i & ~flush_i` and `rdata_o = wdata_i`.
  - If push and pop occur in the same cycle, nothing is written to storage and the pointers and count are unchanged.
- Flush: with `flush_i` high, on the next edge the pointers and `usage` go to 0. Data presented in that cycle is neither stored nor consumed. `max_usage_o` is not affected.
- Thresholds are sampled continuously and the flags are combinational from registered `usage`:
  - `af_thr_i > DEPTH` means `almost_full_o` never asserts.
  - `af_thr_i == 0` means `almost_full_o` is always asserted.
  - `ae_thr_i >= DEPTH` means `almost_empty_o` is always asserted.
- Watermark: each edge, `max_usage` becomes `max(max_usage, usage_next)`. When `wm_clr_i` is high, `max_usage` loads `usage_next` instead.
- Storage contents are not reset. `rdata_o` is don't-care while `rvalid_o` is 0; the verification bench must not check it.

## Timing
- Reset values, applied at the first edge with `reset` high:
  - pointers = 0, `usage_o` = 0, `max_usage_o` = 0;
  - `wready_o` = 1 and `rvalid_o` = 0;
  - `almost_empty_o` = 1; `almost_full_o` = 1 only if `af_thr_i == 0`.
- Reset mid-operation discards all contents at that edge. No partial handshakes survive.
- Latency with `FALL_THROUGH=0`: a write accepted at edge N gives `rvalid_o` high after edge N, so data is readable in cycle N+1.
- Latency with `FALL_THROUGH=1` and an empty FIFO: zero cycles, combinational write-to-read.
- Handshake rules:
  - `rdata_o` is stable while `rvalid_o & ~rready_i`.
  - `wready_o` deasserts in the cycle after the edge that makes `usage == DEPTH`.
- Throughput is one push and one pop per cycle sustained whenever `0 < usage < DEPTH`.
- `usage_o` and `max_usage_o` are registered. The flags follow combinationally from `usage_o` and the threshold inputs.

## Test plan
- **Fill and drain, non-power-of-two depth.** `DEPTH=5`, `FALL_THROUGH=0`, `af_thr=4`, `rready=0`. Offer 0x11..0x17 → exactly 5 accepted; `wready_o=0` with `usage=5`; `almost_full_o` rises when `usage=4`. Then set `rready=1` → 0x11..0x15 are read in order, `usage` returns to 0, `almost_empty_o=1` (with `ae_thr=0`).
- **Steady state across wrap.** At `usage=3`, hold `wvalid=rready=1` for 12 cycles with incrementing data → `usage` stays 3, output order is strictly FIFO across pointer wrap, and `max_usage_o=3`.
- **Fall-through.** `FALL_THROUGH=1`, FIFO empty, `wdata=0xA5`, `wvalid=rready=1` → `rvalid_o=1` and `rdata_o=0xA5` in the same cycle; `usage` stays 0. Repeat with `rready=0` → `usage=1` next cycle and 0xA5 is held.
- **Flush mid-traffic.** Flush at `usage=4` with `wvalid=rready=1` → in that cycle `wready_o=rvalid_o=0`; next cycle `usage=0`, no data lost or duplicated afterwards, `max_usage_o=4`.
- **Watermark.** Fill to 3, drain to 0, fill to 2 → `max_usage_o=3`. Pulse `wm_clr_i` together with a push at `usage=2` → `max_usage_o=3` (it loads `usage_next=3`). Then pop → value held at 3.
- **Reset mid-operation.** At `usage=4`, assert `reset` for 1 cycle with `wvalid=1` → next cycle `usage=0`, `max_usage_o=0`, `rvalid_o=0`, `wready_o=1`. The first word written after reset is the first word read.
